// File: rtl/sprite_sched_if.sv
// Host, frame-timing and sprite-core signals of the per-frame sprite sequencer.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface sprite_sched_if #(parameter int AW = 4);
  logic        frame_start;
  logic [15:0] player_x;
  logic [15:0] player_y;
  logic [6:0]  player_angle;
  logic [6:0]  sprite_count;
  logic        host_we;
  logic [AW-1:0] host_addr;
  logic [39:0] host_wdata;
  logic        host_wr_drop;
  logic [6:0]  angle_addr;
  logic [15:0] spr_map_pos_x;
  logic [15:0] spr_map_pos_y;
  logic [6:0]  smeta_waddr;
  logic [39:0] smeta_write_data;
  logic        smeta_write_en;
  logic        spr_start;
  logic        spr_done;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic        overrun;

  modport master (
    input  frame_start, player_x, player_y, player_angle, sprite_count,
           host_we, host_addr, host_wdata, spr_done,
    output host_wr_drop, angle_addr, spr_map_pos_x, spr_map_pos_y,
           smeta_waddr, smeta_write_data, smeta_write_en, spr_start,
           busy, frame_done, timeout_err, overrun
  );

  modport slave (
    output frame_start, player_x, player_y, player_angle, sprite_count,
           host_we, host_addr, host_wdata, spr_done,
    input  host_wr_drop, angle_addr, spr_map_pos_x, spr_map_pos_y,
           smeta_waddr, smeta_write_data, smeta_write_en, spr_start,
           busy, frame_done, timeout_err, overrun
  );
endinterface

// File: rtl/sprite_sched.sv
// Per-frame sprite sequencer: latch pose, upload sprite table, start the core, await done or timeout.
// Every output is registered; frame requests and host writes arriving mid-frame are dropped and flagged.
module sprite_sched #(
  parameter int MAX_SPRITES = 16,
  parameter int TIMEOUT     = 4095
) (
  input logic            clk,
  input logic            rst,
  sprite_sched_if.master bus
);
  localparam int AW = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LATCH, UPLOAD, START, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [39:0]   tbl [MAX_SPRITES];
  logic [7:0]    n, n_nxt;
  logic [6:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   pos_x, pos_x_nxt, pos_y, pos_y_nxt;
  logic [6:0]    angle, angle_nxt;
  logic          tmo_err, tmo_err_nxt;
  logic [6:0]    waddr, waddr_nxt;
  logic [39:0]   wdata, wdata_nxt;
  logic          we, we_nxt, start, start_nxt, busy_q, busy_nxt;
  logic          fdone, fdone_nxt, over, over_nxt, drop, drop_nxt;
  logic [AW-1:0] rd_idx;
  logic          idle;

  assign idle = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_SPRITES; k++) tbl[k] <= '0;
    end else if (bus.host_we && idle && (32'(bus.host_addr) < MAX_SPRITES)) begin
      tbl[bus.host_addr] <= bus.host_wdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    n_nxt       = n;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    pos_x_nxt   = pos_x;
    pos_y_nxt   = pos_y;
    angle_nxt   = angle;
    tmo_err_nxt = tmo_err;
    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          pos_x_nxt   = bus.player_x;
          pos_y_nxt   = bus.player_y;
          angle_nxt   = bus.player_angle;
          n_nxt       = ({1'b0, bus.sprite_count} > 8'(MAX_SPRITES)) ?
                        8'(MAX_SPRITES) : {1'b0, bus.sprite_count};
          tmo_err_nxt = 1'b0;
          state_nxt   = LATCH;
        end
      end
      LATCH: begin
        idx_nxt   = '0;
        state_nxt = (n == 8'd0) ? DONE : UPLOAD;
      end
      UPLOAD: begin
        if ({1'b0, idx} == n - 8'd1) state_nxt = START;
        else idx_nxt = idx + 7'd1;
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done wins over a coincident timeout; the counter runs TIMEOUT+1 WAIT cycles
        if (bus.spr_done) begin
          state_nxt = DONE;
        end else if (cnt == CW'(TIMEOUT)) begin
          tmo_err_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt  = (state_nxt != IDLE);
    fdone_nxt = (state_nxt == DONE);
    start_nxt = (state_nxt == START);
    we_nxt    = (state_nxt == UPLOAD);
    rd_idx    = idx_nxt[AW-1:0];
    waddr_nxt = we_nxt ? idx_nxt : 7'd0;
    wdata_nxt = we_nxt ? tbl[rd_idx] : 40'd0;
    over_nxt  = bus.frame_start && !idle;
    drop_nxt  = bus.host_we && !idle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n       <= '0;
      idx     <= '0;
      cnt     <= '0;
      pos_x   <= '0;
      pos_y   <= '0;
      angle   <= '0;
      tmo_err <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      we      <= 1'b0;
      start   <= 1'b0;
      busy_q  <= 1'b0;
      fdone   <= 1'b0;
      over    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_nxt;
      n       <= n_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      pos_x   <= pos_x_nxt;
      pos_y   <= pos_y_nxt;
      angle   <= angle_nxt;
      tmo_err <= tmo_err_nxt;
      waddr   <= waddr_nxt;
      wdata   <= wdata_nxt;
      we      <= we_nxt;
      start   <= start_nxt;
      busy_q  <= busy_nxt;
      fdone   <= fdone_nxt;
      over    <= over_nxt;
      drop    <= drop_nxt;
    end
  end

  assign bus.host_wr_drop     = drop;
  assign bus.angle_addr       = angle;
  assign bus.spr_map_pos_x    = pos_x;
  assign bus.spr_map_pos_y    = pos_y;
  assign bus.smeta_waddr      = waddr;
  assign bus.smeta_write_data = wdata;
  assign bus.smeta_write_en   = we;
  assign bus.spr_start        = start;
  assign bus.busy             = busy_q;
  assign bus.frame_done       = fdone;
  assign bus.timeout_err      = tmo_err;
  assign bus.overrun          = over;
endmodule

// File: tb/tb_sprite_sched.sv
// Bench for sprite_sched: frame-relative timeline model checked every cycle, plus directed literal checks.
module tb_sprite_sched;
  localparam int MAXS = 16;
  localparam int TMO  = 10;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_sched_if #(.AW(AW)) bus();
  sprite_sched #(.MAX_SPRITES(MAXS), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;
  int done_mode = 0;
  bit pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Model: a frame is a timeline indexed from the accepting cycle (t=0).
  int          m_t, m_n, m_fd;
  bit          m_act, m_tmo_hit;
  logic [39:0] m_tab [MAXS];
  logic        e_busy, e_fd, e_we, e_start, e_tmo, e_over, e_drop;
  logic [6:0]  e_waddr, e_angle;
  logic [39:0] e_wdata;
  logic [15:0] e_x, e_y;

  always @(posedge clk) begin
    armed = 1'b1;
    if (rst) begin
      m_act = 0; m_t = 0; m_n = 0; m_fd = -1; m_tmo_hit = 0;
      for (int k = 0; k < MAXS; k++) m_tab[k] = '0;
      e_busy = 0; e_tmo = 0; e_over = 0; e_drop = 0;
      e_x = '0; e_y = '0; e_angle = '0;
    end else begin
      e_over = bus.frame_start && e_busy;
      e_drop = bus.host_we && e_busy;
      if (bus.host_we && !e_busy) m_tab[bus.host_addr] = bus.host_wdata;
      if (m_act) begin
        if (m_fd < 0 && m_t >= m_n + 3) begin
          if (bus.spr_done) m_fd = m_t + 1;
          else if (m_t == m_n + 3 + TMO) begin m_fd = m_t + 1; m_tmo_hit = 1; end
        end
        m_t++;
        if (m_fd >= 0 && m_t > m_fd) m_act = 0;
      end else if (bus.frame_start && !e_busy) begin
        m_act = 1; m_t = 1; m_tmo_hit = 0; e_tmo = 0;
        m_n = (int'(bus.sprite_count) > MAXS) ? MAXS : int'(bus.sprite_count);
        m_fd = (m_n == 0) ? 2 : -1;
        e_x = bus.player_x; e_y = bus.player_y; e_angle = bus.player_angle;
      end
    end
    e_busy  = m_act;
    e_fd    = m_act && (m_t == m_fd);
    e_we    = m_act && m_n > 0 && m_t >= 2 && m_t <= m_n + 1;
    e_waddr = e_we ? 7'(m_t - 2) : 7'd0;
    e_wdata = e_we ? m_tab[m_t - 2] : 40'd0;
    e_start = m_act && m_n > 0 && (m_t == m_n + 2);
    if (e_fd && m_tmo_hit) e_tmo = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", bus.busy, e_busy);
      chk("frame_done", bus.frame_done, e_fd);
      chk("we", bus.smeta_write_en, e_we);
      chk("waddr", bus.smeta_waddr, e_waddr);
      chk("wdata", bus.smeta_write_data, e_wdata);
      chk("spr_start", bus.spr_start, e_start);
      chk("timeout_err", bus.timeout_err, e_tmo);
      chk("overrun", bus.overrun, e_over);
      chk("wr_drop", bus.host_wr_drop, e_drop);
      chk("pos_x", bus.spr_map_pos_x, e_x);
      chk("pos_y", bus.spr_map_pos_y, e_y);
      chk("angle", bus.angle_addr, e_angle);
    end
  end

  // Stand-in for the sprite core's done: 0 = never, 1 = random, 2 = two cycles after start.
  always @(negedge clk) begin
    case (done_mode)
      0: begin bus.spr_done = 1'b0; pend = 1'b0; end
      1: begin bus.spr_done = ($urandom_range(0, 7) == 0); pend = 1'b0; end
      default: begin bus.spr_done = pend; pend = bus.spr_start; end
    endcase
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic hw(input logic [AW-1:0] a, input logic [39:0] d);
    bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    cyc();
    bus.host_we = 1'b0;
  endtask

  task automatic frame(input logic [6:0] cnt, input logic [15:0] x, input logic [15:0] y,
                       input logic [6:0] ang);
    bus.frame_start = 1'b1; bus.sprite_count = cnt;
    bus.player_x = x; bus.player_y = y; bus.player_angle = ang;
    cyc();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin cyc(); k++; end
    if (k >= 100) chk("idle_wait", 64'd1, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    logic [6:0] last;
    bus.frame_start = 0; bus.player_x = 0; bus.player_y = 0; bus.player_angle = 0;
    bus.sprite_count = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    repeat (3) cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_tmo", bus.timeout_err, 0);
    chk("rst_we", bus.smeta_write_en, 0);
    rst = 1'b0;
    cyc();

    // three-sprite frame
    done_mode = 2;
    hw(0, 40'h01_1200_1200); hw(1, 40'h02_0800_0900); hw(2, 40'h03_1400_0A00);
    frame(7'd3, 16'h0D00, 16'h0D00, 7'd0);
    chk("A_busy_c1", bus.busy, 1);
    chk("A_posx_c1", bus.spr_map_pos_x, 16'h0D00);
    cyc(); chk("A_waddr_c2", bus.smeta_waddr, 0); chk("A_data_c2", bus.smeta_write_data, 40'h01_1200_1200);
    cyc(); chk("A_waddr_c3", bus.smeta_waddr, 1); chk("A_data_c3", bus.smeta_write_data, 40'h02_0800_0900);
    cyc(); chk("A_waddr_c4", bus.smeta_waddr, 2); chk("A_data_c4", bus.smeta_write_data, 40'h03_1400_0A00);
    cyc(); chk("A_start_c5", bus.spr_start, 1);
    cyc(); cyc(); chk("A_fd_c7", bus.frame_done, 1);
    cyc(); chk("A_busy_c8", bus.busy, 0);

    // zero sprites
    frame(7'd0, 16'h0100, 16'h0200, 7'd5);
    cyc(); chk("B_fd_c2", bus.frame_done, 1);
    cyc(); chk("B_busy_c3", bus.busy, 0);

    // timeout
    done_mode = 0;
    frame(7'd1, 16'h0300, 16'h0400, 7'd9);
    cyc(); cyc(); chk("C_start_c3", bus.spr_start, 1);
    repeat (12) cyc();
    chk("C_fd_c15", bus.frame_done, 1); chk("C_tmo_c15", bus.timeout_err, 1);
    cyc(); chk("C_tmo_c16", bus.timeout_err, 1);
    done_mode = 2;
    frame(7'd1, 16'h0300, 16'h0400, 7'd9);
    chk("C_tmo_clr_c1", bus.timeout_err, 0);
    wait_idle();

    // clamp to table depth
    frame(7'd100, 16'h0500, 16'h0600, 7'd1);
    nw = 0; last = '0;
    for (int k = 0; k < 20; k++) begin
      if (bus.smeta_write_en) begin nw++; last = bus.smeta_waddr; end
      cyc();
    end
    chk("D_nwrites", nw, 16);
    chk("D_last_waddr", last, 15);
    wait_idle();

    // overrun and dropped host write during WAIT
    done_mode = 0;
    frame(7'd2, 16'h0700, 16'h0800, 7'd2);
    repeat (5) cyc();
    bus.frame_start = 1; bus.host_we = 1; bus.host_addr = 1; bus.host_wdata = 40'hFF_FFFF_FFFF;
    cyc();
    bus.frame_start = 0; bus.host_we = 0;
    chk("E_overrun", bus.overrun, 1); chk("E_drop", bus.host_wr_drop, 1);
    cyc(); chk("E_overrun_off", bus.overrun, 0); chk("E_drop_off", bus.host_wr_drop, 0);
    wait_idle();
    done_mode = 2;
    frame(7'd2, 16'h0700, 16'h0800, 7'd2);
    cyc(); cyc(); chk("E_tab1_kept", bus.smeta_write_data, 40'h02_0800_0900);
    wait_idle();

    // reset mid-upload
    frame(7'd5, 16'h0900, 16'h0A00, 7'd3);
    cyc(); cyc(); rst = 1'b1;
    cyc();
    chk("F_busy", bus.busy, 0); chk("F_we", bus.smeta_write_en, 0);
    chk("F_posx", bus.spr_map_pos_x, 0); chk("F_angle", bus.angle_addr, 0);
    rst = 1'b0;
    cyc();
    frame(7'd2, 16'h0B00, 16'h0C00, 7'd4);
    cyc(); chk("F_we_c2", bus.smeta_write_en, 1); chk("F_waddr_c2", bus.smeta_waddr, 0);
    wait_idle();

    // randomized traffic
    done_mode = 1;
    for (int it = 0; it < 600; it++) begin
      bus.host_we    = ($urandom_range(0, 3) == 0);
      bus.host_addr  = AW'($urandom);
      bus.host_wdata = {8'($urandom), 32'($urandom)};
      bus.frame_start = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: bus.sprite_count = 7'd0;
        1: bus.sprite_count = 7'($urandom_range(1, 3));
        2: bus.sprite_count = 7'($urandom_range(14, 20));
        default: bus.sprite_count = 7'($urandom);
      endcase
      bus.player_x = 16'($urandom); bus.player_y = 16'($urandom);
      bus.player_angle = 7'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0; bus.host_we = 0; bus.frame_start = 0;
    wait_idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_sched.md
# sprite_sched

Per-frame sequencer for the `sprite` projection unit. On each frame request it latches the player pose, drives the `angle_rom` address, and uploads the host-maintained sprite table into the sprite core's metadata RAM. It then pulses `start`, waits for `done` with a timeout, and reports frame completion. It sits between the host/frame-timing logic and the `sprite` + `angle_rom` pair. The renderer keeps reading `stmeta` results directly from `sprite`.

## Interface
Parameters:
- MAX_SPRITES, 16: sprite table depth. Must be 1..128.
- TIMEOUT, 4095: maximum number of WAIT cycles before the frame is abandoned.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that requests a sprite pass.
- player_x  in  16  player X, Q8.8. Sampled with frame_start.
- player_y  in  16  player Y, Q8.8. Sampled with frame_start.
- player_angle  in  7  angle_rom index. Sampled with frame_start.
- sprite_count  in  7  number of active sprites. Sampled with frame_start.
- host_we  in  1  sprite table write strobe.
- host_addr  in  $clog2(MAX_SPRITES)  sprite table index.
- host_wdata  in  40  table entry, {tex[7:0], x Q8.8, y Q8.8}.
- host_wr_drop  out  1  one-cycle pulse: a host write arrived while busy and was discarded.
- angle_addr  out  7  address to angle_rom (1-cycle synchronous ROM).
- spr_map_pos_x  out  16  drives sprite map_pos_x.
- spr_map_pos_y  out  16  drives sprite map_pos_y.
- smeta_waddr  out  7  drives sprite smeta_waddr.
- smeta_write_data  out  40  drives sprite smeta_write_data.
- smeta_write_en  out  1  drives sprite smeta_write_en.
- spr_start  out  1  drives sprite start. One-cycle pulse.
- spr_done  in  1  sprite done.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky; set on timeout, cleared by the next accepted frame_start.
- overrun  out  1  one-cycle pulse: frame_start arrived while busy.

## Operation
- Sprite table: MAX_SPRITES x 40-bit register array, read combinationally by index.
  - In IDLE, a host write lands on the clock edge.
  - When busy, host writes are dropped and host_wr_drop pulses on the following cycle.
- FSM states: IDLE, LATCH, UPLOAD, START, WAIT, DONE.
- IDLE:
  - On frame_start, register player_x/y into spr_map_pos_x/y and player_angle into angle_addr.
  - Register n = min(sprite_count, MAX_SPRITES).
  - Clear timeout_err, then go to LATCH.
- LATCH: one cycle for the ROM access.
  - n == 0: go to DONE. No upload and no spr_start.
  - Otherwise: go to UPLOAD with index i = 0.
- UPLOAD:
  - Each cycle: smeta_write_en = 1, smeta_waddr = i, smeta_write_data = table[i].
  - After i == n-1, go to START.
- START: spr_start = 1 for one cycle. Clear the timeout counter, then go to WAIT.
- WAIT:
  - spr_done == 1: go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, set timeout_err and go to DONE.
- DONE: frame_done = 1 for one cycle, then go to IDLE.
- spr_done is ignored outside WAIT.
- frame_start is ignored outside IDLE and produces an overrun pulse one cycle later.
- Reset values:
  - State is IDLE and all table entries are 0.
  - Every output is 0: angle_addr, spr_map_pos_x/y, smeta_*, spr_start, busy, frame_done, timeout_err, overrun, host_wr_drop.
- Reset mid-frame: return to IDLE next cycle with all outputs 0. No partial start is issued.
- Outputs spr_map_pos_x/y and angle_addr hold their values from LATCH through the next accepted frame_start.

## Timing
- Cycle 0 = the IDLE cycle where frame_start is sampled high.
- Cycle 1: LATCH. busy = 1; angle_addr and spr_map_pos_* show the new values.
- Cycles 2 .. n+1: UPLOAD, with smeta_write_en high for exactly n cycles.
- Cycle n+2: spr_start high. The angle ROM data has been valid since cycle 2.
- WAIT begins at cycle n+3.
- If spr_done is sampled high at cycle k, frame_done is high at k+1. busy goes low at k+2, which is the earliest cycle a new frame_start is accepted.
- Timeout: frame_done fires at cycle n+3+TIMEOUT+1.
- n == 0: frame_done is high at cycle 2 and busy is low at cycle 3.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Three-sprite frame:
  - Stimulus: write table[0..2] = 40'h01_1200_1200, 40'h02_0800_0900, 40'h03_1400_0A00; frame_start with count 3, pos 13.00/13.00, angle 0; real sprite + angle_rom attached.
  - Required: smeta_write_en high at cycles 2-4 with waddr 0,1,2 and matching data; spr_start at cycle 5; frame_done one cycle after done; stmeta_raddr 0 readback is non-zero.
- count = 0: no smeta_write_en and no spr_start; frame_done at cycle 2; busy low at cycle 3.
- Timeout:
  - Stimulus: TIMEOUT = 10, spr_done tied low, count 1.
  - Required: spr_start at cycle 3; frame_done at cycle 15; timeout_err = 1 and held; next frame_start clears it at cycle 1.
- Clamp: MAX_SPRITES = 16, count = 100 gives exactly 16 writes, waddr 0-15.
- Overrun / drop:
  - Stimulus: during WAIT, pulse frame_start and host_we (addr 1, new data).
  - Required: overrun and host_wr_drop each pulse once; table[1] unchanged in the next frame's upload.
- Reset mid-UPLOAD: assert rst at cycle 3. Required: next cycle all outputs are 0, and a later frame_start restarts cleanly from waddr 0.
